// File: rtl/iosc_skin.sv
// Skin-side register block for the core IO shell: timer, interrupt pending/mask, software interrupt, scratch and ID.
// Optional build macro IOSC_SKIN_PRESCALE_EN adds an 8-bit timer prescaler (PRESC register at offset 0x20).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module iosc_skin #(
  parameter logic [`DATA_WIDTH-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [`DATA_WIDTH-1:0] ID_VALUE  = 32'h1050_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_oen,
  input  logic                   i_ien,
  input  logic [`DATA_WIDTH-1:0] i_addr,
  input  logic [`DATA_WIDTH-1:0] i_data,
  output logic [`DATA_WIDTH-1:0] o_data,
  output logic [`DATA_WIDTH-1:0] o_interrupt
);

  localparam int W = `DATA_WIDTH;

  localparam logic [3:0] IDX_CTRL    = 4'h0;
  localparam logic [3:0] IDX_LOAD    = 4'h1;
  localparam logic [3:0] IDX_COUNT   = 4'h2;
  localparam logic [3:0] IDX_PEND    = 4'h3;
  localparam logic [3:0] IDX_MASK    = 4'h4;
  localparam logic [3:0] IDX_SWI     = 4'h5;
  localparam logic [3:0] IDX_SCRATCH = 4'h6;
  localparam logic [3:0] IDX_ID      = 4'h7;
  localparam logic [3:0] IDX_PRESC   = 4'h8;

  logic         sel;
  logic         wr;
  logic         rd;
  logic [3:0]   idx;
  logic         wr_ctrl;
  logic         wr_count;

  logic         ctrl_en;
  logic         ctrl_reload;
  logic [W-1:0] load_q;
  logic [W-1:0] count_q;
  logic [1:0]   pend_q;
  logic [1:0]   mask_q;
  logic [W-1:0] scratch_q;

  logic         tick;
  logic         expire;
  logic         swi_set;
  logic [W-1:0] rdata;

  logic         unused_addr;

  assign sel      = (i_addr[W-1:8] == BASE_ADDR[W-1:8]);
  assign wr       = i_oen & sel;
  assign rd       = i_ien & sel;
  assign idx      = i_addr[5:2];
  assign wr_ctrl  = wr && (idx == IDX_CTRL);
  assign wr_count = wr && (idx == IDX_COUNT);

  assign unused_addr = &{1'b0, i_addr[7:6], i_addr[1:0]};

`ifdef IOSC_SKIN_PRESCALE_EN
  logic [7:0] presc_q;
  logic [7:0] psc_cnt;

  // Tick fires on the cycle the prescaler reaches PRESC, giving one tick every PRESC+1 cycles.
  assign tick = ctrl_en && (psc_cnt == presc_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      psc_cnt <= '0;
    end else begin
      if (wr && (idx == IDX_PRESC))
        presc_q <= i_data[7:0];
      if (!ctrl_en || wr_ctrl || wr_count || (psc_cnt == presc_q))
        psc_cnt <= '0;
      else
        psc_cnt <= psc_cnt + 8'd1;
    end
  end
`else
  assign tick = ctrl_en;
`endif

  assign expire  = tick && (count_q == '0);
  assign swi_set = wr && (idx == IDX_SWI) && i_data[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      load_q      <= '0;
      count_q     <= '0;
      mask_q      <= '0;
      scratch_q   <= '0;
    end else begin
      // Bus writes take priority over the timer's own updates to CTRL and COUNT.
      if (wr_ctrl) begin
        ctrl_en     <= i_data[0];
        ctrl_reload <= i_data[1];
      end else if (expire && !ctrl_reload) begin
        ctrl_en <= 1'b0;
      end

      if (wr_count)
        count_q <= i_data;
      else if (tick && (count_q != '0))
        count_q <= count_q - 1'b1;
      else if (expire && ctrl_reload)
        count_q <= load_q;

      if (wr && (idx == IDX_LOAD))
        load_q <= i_data;
      if (wr && (idx == IDX_MASK))
        mask_q <= i_data[1:0];
      if (wr && (idx == IDX_SCRATCH))
        scratch_q <= i_data;
    end
  end

  // Set events beat a same-cycle write-1-to-clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      if (expire)
        pend_q[0] <= 1'b1;
      else if (wr && (idx == IDX_PEND) && i_data[0])
        pend_q[0] <= 1'b0;

      if (swi_set)
        pend_q[1] <= 1'b1;
      else if (wr && (idx == IDX_PEND) && i_data[1])
        pend_q[1] <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_CTRL:    rdata[1:0] = {ctrl_reload, ctrl_en};
      IDX_LOAD:    rdata = load_q;
      IDX_COUNT:   rdata = count_q;
      IDX_PEND:    rdata[1:0] = pend_q;
      IDX_MASK:    rdata[1:0] = mask_q;
      IDX_SCRATCH: rdata = scratch_q;
      IDX_ID:      rdata = ID_VALUE;
`ifdef IOSC_SKIN_PRESCALE_EN
      IDX_PRESC:   rdata[7:0] = presc_q;
`endif
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data      <= '0;
      o_interrupt <= '0;
    end else begin
      if (rd)
        o_data <= rdata;
      o_interrupt <= {{(W-2){1'b0}}, pend_q & mask_q};
    end
  end

endmodule

// File: tb/tb_iosc_skin.sv
// Directed self-checking bench for iosc_skin: bus access, timer modes, interrupts, reset and prescaler.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_iosc_skin;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_CTRL    = BASE + 32'h00;
  localparam logic [31:0] A_LOAD    = BASE + 32'h04;
  localparam logic [31:0] A_COUNT   = BASE + 32'h08;
  localparam logic [31:0] A_PEND    = BASE + 32'h0C;
  localparam logic [31:0] A_MASK    = BASE + 32'h10;
  localparam logic [31:0] A_SWI     = BASE + 32'h14;
  localparam logic [31:0] A_SCRATCH = BASE + 32'h18;
  localparam logic [31:0] A_ID      = BASE + 32'h1C;
  localparam logic [31:0] A_PRESC   = BASE + 32'h20;

`ifdef IOSC_SKIN_PRESCALE_EN
  localparam int EXPIRE_DELAY = 12;
`else
  localparam int EXPIRE_DELAY = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        i_oen;
  logic        i_ien;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic [31:0] o_interrupt;

  int total;
  int bad;

  iosc_skin dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_oen       (i_oen),
    .i_ien       (i_ien),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .o_data      (o_data),
    .o_interrupt (o_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one bus cycle starting at a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic oen, input logic ien, input logic [31:0] addr,
                               input logic [31:0] data);
    i_oen  = oen;
    i_ien  = ien;
    i_addr = addr;
    i_data = data;
    @(negedge clk);
    i_oen = 1'b0;
    i_ien = 1'b0;
  endtask

  task automatic writeReg(input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, addr, data);
  endtask

  task automatic readCheck(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, 1'b1, addr, 32'h0);
    checkOutput(tag, o_data, exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst_n  = 1'b0;
    i_oen  = 1'b0;
    i_ien  = 1'b0;
    i_addr = '0;
    i_data = '0;
    @(negedge clk);
    checkOutput("reset_odata", o_data, 32'h0);
    checkOutput("reset_irq", o_interrupt, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    writeReg(A_SCRATCH, 32'hDEAD_BEEF);
    writeReg(A_MASK, 32'h3);
    writeReg(A_SWI, 32'h1);
    idle(1);
    readCheck("scratch_pre_reset", A_SCRATCH, 32'hDEAD_BEEF);
    checkOutput("irq_pre_reset", o_interrupt, 32'h2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_odata", o_data, 32'h0);
    checkOutput("async_reset_irq", o_interrupt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    readCheck("scratch_after_reset", A_SCRATCH, 32'h0);

    writeReg(A_SCRATCH, 32'hA5A5_0F0F);
    readCheck("scratch_rw", A_SCRATCH, 32'hA5A5_0F0F);
    readCheck("id", A_ID, 32'h1050_0001);
    applyStimulus(1'b0, 1'b1, 32'h0000_2018, 32'h0);
    checkOutput("unsel_read_hold", o_data, 32'h1050_0001);
    readCheck("unmapped_24", BASE + 32'h24, 32'h0);
    readCheck("presc_reset", A_PRESC, 32'h0);
    writeReg(32'h0000_2018, 32'h1234_5678);
    readCheck("unsel_write_ignored", A_SCRATCH, 32'hA5A5_0F0F);
    writeReg(A_LOAD, 32'hFFFF_0001);
    readCheck("load_rw", A_LOAD, 32'hFFFF_0001);
    writeReg(A_CTRL, 32'hFFFF_FFFC);
    readCheck("ctrl_mask_bits", A_CTRL, 32'h0);
    readCheck("swi_reads_zero", A_SWI, 32'h0);
    applyStimulus(1'b1, 1'b1, A_SCRATCH, 32'h1111_1111);
    checkOutput("rw_same_cycle_old", o_data, 32'hA5A5_0F0F);
    readCheck("rw_same_cycle_new", A_SCRATCH, 32'h1111_1111);

    // One-shot timer: each read returns COUNT as it was just before its edge.
    writeReg(A_MASK, 32'h1);
    writeReg(A_COUNT, 32'h3);
    writeReg(A_CTRL, 32'h1);
    readCheck("oneshot_cnt3", A_COUNT, 32'h3);
    readCheck("oneshot_cnt2", A_COUNT, 32'h2);
    readCheck("oneshot_cnt1", A_COUNT, 32'h1);
    readCheck("oneshot_cnt0", A_COUNT, 32'h0);
    checkOutput("oneshot_irq_lag", o_interrupt, 32'h0);
    readCheck("oneshot_pend", A_PEND, 32'h1);
    checkOutput("oneshot_irq", o_interrupt, 32'h1);
    readCheck("oneshot_en_clear", A_CTRL, 32'h0);
    readCheck("oneshot_cnt_stay", A_COUNT, 32'h0);
    writeReg(A_PEND, 32'h1);
    readCheck("pend_w1c", A_PEND, 32'h0);

    // Auto-reload: expiries on the 1st, 4th and 7th edges after the CTRL write.
    writeReg(A_LOAD, 32'h2);
    writeReg(A_COUNT, 32'h0);
    writeReg(A_CTRL, 32'h3);
    readCheck("reload_cnt0", A_COUNT, 32'h0);
    readCheck("reload_cnt2", A_COUNT, 32'h2);
    readCheck("reload_cnt1", A_COUNT, 32'h1);
    readCheck("reload_cnt0b", A_COUNT, 32'h0);
    writeReg(A_PEND, 32'h1);
    readCheck("reload_pend_cleared", A_PEND, 32'h0);
    writeReg(A_PEND, 32'h1);
    readCheck("reload_set_wins", A_PEND, 32'h1);
    readCheck("reload_cnt_after", A_COUNT, 32'h1);
    writeReg(A_CTRL, 32'h0);
    writeReg(A_PEND, 32'h1);
    readCheck("reload_stopped", A_PEND, 32'h0);

    // Software interrupt and mask.
    writeReg(A_MASK, 32'h0);
    writeReg(A_SWI, 32'h1);
    readCheck("swi_pend", A_PEND, 32'h2);
    checkOutput("swi_masked", o_interrupt, 32'h0);
    writeReg(A_MASK, 32'h2);
    checkOutput("swi_mask_lag", o_interrupt, 32'h0);
    idle(1);
    checkOutput("swi_irq", o_interrupt, 32'h2);
    writeReg(A_PEND, 32'h2);
    checkOutput("swi_clear_lag", o_interrupt, 32'h2);
    idle(1);
    checkOutput("swi_irq_clear", o_interrupt, 32'h0);

    // Prescaled (or per-cycle) one-shot expiry timing seen through o_interrupt.
    writeReg(A_MASK, 32'h1);
    writeReg(A_PRESC, 32'h3);
`ifdef IOSC_SKIN_PRESCALE_EN
    readCheck("presc_rw", A_PRESC, 32'h3);
`else
    readCheck("presc_absent", A_PRESC, 32'h0);
`endif
    writeReg(A_COUNT, 32'h2);
    writeReg(A_CTRL, 32'h1);
    idle(EXPIRE_DELAY);
    checkOutput("presc_before_irq", o_interrupt, 32'h0);
    idle(1);
    checkOutput("presc_irq", o_interrupt, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
